dot_tracker: RTL

Receiving end of the 16-bit one-hot "sliding dot" LED bus. Samples the pattern driven by the dot generator, encodes the dot position, detects single-position steps and their direction, measures how many cycles each position was held, counts completed passes (dot shifted out past bit 0), and flags malformed patterns. It sits beside the LED outputs as a monitor and self-check for the display path, feeding position and status to the 7-segment and debug logic.

---
 rtl/dot_pkg.sv | 19 +
 rtl/onehot_classifier.sv | 40 ++++
 rtl/dot_tracker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared types for the sliding-dot LED bus monitors: FSM states, pattern classes
// and the default bus width.
package dot_pkg;

  localparam int DOT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    ONEHOT = 2'd1,
    MULTI  = 2'd2
  } class_e;

endpackage

// File: rtl/onehot_classifier.sv
// Combinational classifier for an LED-bus pattern: no bits, exactly one bit (with
// its index) or several bits set.
module onehot_classifier
  import dot_pkg::*;
#(
  parameter int WIDTH = DOT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_pattern,
  output class_e           o_class,
  output logic [IDX_W-1:0] o_index
);

  logic [WIDTH-1:0] w_rest;
  logic [IDX_W-1:0] w_index;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign w_rest = i_pattern & (i_pattern - WIDTH'(1));

  always_comb begin
    w_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_pattern[i]) begin
        w_index = w_index | IDX_W'(i);
      end
    end
  end

  always_comb begin
    o_class = ZERO;
    if (w_rest != '0) begin
      o_class = MULTI;
    end else if (i_pattern != '0) begin
      o_class = ONEHOT;
    end
  end

  assign o_index = w_index;

endmodule

// File: rtl/dot_tracker.sv
// Monitor for the one-hot sliding-dot LED bus: tracks dot position, step direction,
// per-position dwell time and completed passes, and flags malformed patterns.
module dot_tracker
  import dot_pkg::*;
#(
  parameter int WIDTH   = DOT_WIDTH,
  parameter int IDX_W   = $clog2(WIDTH),
  parameter int DWELL_W = 26,
  parameter int PASS_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   dataIn,
  input  logic               clear,
  output logic [IDX_W-1:0]   position,
  output logic               valid,
  output logic               stepPulse,
  output logic               direction,
  output logic [DWELL_W-1:0] dwell,
  output logic [PASS_W-1:0]  passCount,
  output logic               error
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_sample;
  class_e             w_class;
  logic [IDX_W-1:0]   w_index;
  logic [IDX_W:0]     w_idx_ext;
  logic [IDX_W:0]     w_pos_ext;
  logic               w_adjacent;

  logic [IDX_W-1:0]   r_position;
  logic               r_valid;
  logic               r_step;
  logic               r_direction;
  logic [DWELL_W-1:0] r_dwell;
  logic [PASS_W-1:0]  r_pass;
  logic               r_error;
  logic [DWELL_W-1:0] r_dwell_cnt;

  logic [IDX_W-1:0]   w_position_nxt;
  logic               w_step_nxt;
  logic               w_direction_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic [PASS_W-1:0]  w_pass_nxt;
  logic               w_error_nxt;
  logic [DWELL_W-1:0] w_dwell_cnt_nxt;
  logic [DWELL_W-1:0] w_dwell_cnt_inc;

  // Stage p0: sample the bus every cycle, whatever the FSM is doing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample <= '0;
    end else begin
      r_sample <= dataIn;
    end
  end

  onehot_classifier #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_classifier (
    .i_pattern (r_sample),
    .o_class   (w_class),
    .o_index   (w_index)
  );

  // One extra bit keeps 15 and 0 from looking adjacent.
  assign w_idx_ext  = {1'b0, w_index};
  assign w_pos_ext  = {1'b0, r_position};
  assign w_adjacent = (w_idx_ext == w_pos_ext + 1'b1) || (w_pos_ext == w_idx_ext + 1'b1);

  assign w_dwell_cnt_inc = (r_dwell_cnt == '1) ? r_dwell_cnt : r_dwell_cnt + DWELL_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_class == ONEHOT) begin
            w_state_nxt = TRACK;
          end else if (w_class == MULTI) begin
            w_state_nxt = FAULT;
          end
        end
        TRACK: begin
          if (w_class == ZERO) begin
            w_state_nxt = IDLE;
          end else if (w_class == MULTI) begin
            w_state_nxt = FAULT;
          end
        end
        FAULT:   w_state_nxt = FAULT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_position_nxt  = r_position;
    w_step_nxt      = 1'b0;
    w_direction_nxt = r_direction;
    w_dwell_nxt     = r_dwell;
    w_pass_nxt      = r_pass;
    w_error_nxt     = r_error;
    w_dwell_cnt_nxt = r_dwell_cnt;
    if (clear) begin
      w_position_nxt  = '0;
      w_direction_nxt = 1'b0;
      w_dwell_nxt     = '0;
      w_pass_nxt      = '0;
      w_error_nxt     = 1'b0;
      w_dwell_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_class == ONEHOT) begin
            w_position_nxt  = w_index;
            w_dwell_cnt_nxt = DWELL_W'(1);
          end else if (w_class == MULTI) begin
            w_error_nxt = 1'b1;
          end
        end
        TRACK: begin
          case (w_class)
            ONEHOT: begin
              if (w_index == r_position) begin
                w_dwell_cnt_nxt = w_dwell_cnt_inc;
              end else if (w_adjacent) begin
                w_step_nxt      = 1'b1;
                w_direction_nxt = (w_index > r_position);
                w_dwell_nxt     = r_dwell_cnt;
                w_dwell_cnt_nxt = DWELL_W'(1);
                w_position_nxt  = w_index;
              end else begin
                w_error_nxt     = 1'b1;
                w_position_nxt  = w_index;
                w_dwell_cnt_nxt = DWELL_W'(1);
              end
            end
            ZERO: begin
              if (r_position == '0) begin
                w_pass_nxt  = r_pass + PASS_W'(1);
                w_dwell_nxt = r_dwell_cnt;
              end else begin
                w_error_nxt = 1'b1;
              end
            end
            default: w_error_nxt = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_position  <= '0;
      r_valid     <= 1'b0;
      r_step      <= 1'b0;
      r_direction <= 1'b0;
      r_dwell     <= '0;
      r_pass      <= '0;
      r_error     <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      r_position  <= w_position_nxt;
      r_valid     <= (w_state_nxt == TRACK);
      r_step      <= w_step_nxt;
      r_direction <= w_direction_nxt;
      r_dwell     <= w_dwell_nxt;
      r_pass      <= w_pass_nxt;
      r_error     <= w_error_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
    end
  end

  assign position  = r_position;
  assign valid     = r_valid;
  assign stepPulse = r_step;
  assign direction = r_direction;
  assign dwell     = r_dwell;
  assign passCount = r_pass;
  assign error     = r_error;

endmodule
